rcn2avalon: RTL and testbench

//  rcn bus target: converts rcn requests addressed to its window into Avalon-MM master transactions.

---
 rtl/rcn2avalon_if.sv | 22 ++
 rtl/rcn2avalon.sv | 160 ++++++++++++++++
 tb/tb_rcn2avalon.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rcn2avalon_if.sv
// Avalon-MM signal bundle between the rcn2avalon bridge (master) and the attached
// Avalon slave.
interface rcn2avalon_if;
    logic [21:0] av_address;
    logic        av_read;
    logic        av_write;
    logic [3:0]  av_byteenable;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;

    modport master (
        output av_address, av_read, av_write, av_byteenable, av_writedata,
        input  av_waitrequest, av_readdata, av_readdatavalid
    );

    modport slave (
        input  av_address, av_read, av_write, av_byteenable, av_writedata,
        output av_waitrequest, av_readdata, av_readdatavalid
    );
endinterface

// File: rtl/rcn2avalon.sv
// rcn ring target: consumes pending requests in its address window, runs one Avalon-MM
// transfer each, and inserts the response into a later empty slot.
// Optional stall timeout enabled by defining RCN2AVALON_TIMEOUT_EN.
module rcn2avalon #(
    parameter logic [21:0] ADDR_MASK      = 22'h3FFFFF,
    parameter logic [21:0] ADDR_BASE      = 22'h000000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic          av_clk,
    input  logic          av_rst_n,
    input  logic [68:0]   rcn_in,
    output logic [68:0]   rcn_out,
    rcn2avalon_if.master  av
);

    typedef enum logic [1:0] {StIdle, StAvReq, StRdWait, StResp} state_e;

    state_e      r_state, w_state_nxt;
    logic [68:0] r_rin;
    logic [68:0] r_rout, w_rout_nxt;
    logic        r_wr, w_wr_nxt;
    logic [5:0]  r_id, w_id_nxt;
    logic [3:0]  r_mask, w_mask_nxt;
    logic [21:0] r_addr, w_addr_nxt;
    logic [1:0]  r_seq, w_seq_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_rd, w_rd_nxt;
    logic        r_wt, w_wt_nxt;
    logic        w_hit;
    logic        w_my_req;
    logic        w_tmo_hit;

    assign w_hit    = (r_rin[55:34] & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);
    assign w_my_req = r_rin[68] & r_rin[67] & w_hit;

`ifdef RCN2AVALON_TIMEOUT_EN
    logic [15:0] r_tmo, w_tmo_nxt;

    assign w_tmo_hit = (r_tmo == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge av_clk or negedge av_rst_n) begin
        if (!av_rst_n) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_tmo_nxt = r_tmo;
        if (r_state == StIdle) begin
            w_tmo_nxt = '0;
        end else if (r_state == StAvReq || r_state == StRdWait) begin
            w_tmo_nxt = r_tmo + 16'd1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge av_clk or negedge av_rst_n) begin
        if (!av_rst_n) begin
            r_state <= StIdle;
            r_rin   <= '0;
            r_rout  <= '0;
            r_wr    <= 1'b0;
            r_id    <= '0;
            r_mask  <= '0;
            r_addr  <= '0;
            r_seq   <= '0;
            r_data  <= '0;
            r_rd    <= 1'b0;
            r_wt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rin   <= rcn_in;
            r_rout  <= w_rout_nxt;
            r_wr    <= w_wr_nxt;
            r_id    <= w_id_nxt;
            r_mask  <= w_mask_nxt;
            r_addr  <= w_addr_nxt;
            r_seq   <= w_seq_nxt;
            r_data  <= w_data_nxt;
            r_rd    <= w_rd_nxt;
            r_wt    <= w_wt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rout_nxt  = r_rin;
        w_wr_nxt    = r_wr;
        w_id_nxt    = r_id;
        w_mask_nxt  = r_mask;
        w_addr_nxt  = r_addr;
        w_seq_nxt   = r_seq;
        w_data_nxt  = r_data;
        w_rd_nxt    = r_rd;
        w_wt_nxt    = r_wt;

        unique case (r_state)
            StIdle: begin
                if (w_my_req) begin
                    w_wr_nxt    = r_rin[66];
                    w_id_nxt    = r_rin[65:60];
                    w_mask_nxt  = r_rin[59:56];
                    w_addr_nxt  = r_rin[55:34];
                    w_seq_nxt   = r_rin[33:32];
                    w_data_nxt  = r_rin[31:0];
                    w_rout_nxt  = '0;
                    w_rd_nxt    = ~r_rin[66];
                    w_wt_nxt    = r_rin[66];
                    w_state_nxt = StAvReq;
                end
            end
            StAvReq: begin
                if (!av.av_waitrequest) begin
                    w_rd_nxt    = 1'b0;
                    w_wt_nxt    = 1'b0;
                    w_state_nxt = r_wr ? StResp : StRdWait;
                end else if (w_tmo_hit) begin
                    w_rd_nxt    = 1'b0;
                    w_wt_nxt    = 1'b0;
                    w_data_nxt  = 32'hDEAD_DEAD;
                    w_state_nxt = StResp;
                end
            end
            StRdWait: begin
                if (av.av_readdatavalid) begin
                    w_data_nxt  = av.av_readdata;
                    w_state_nxt = StResp;
                end else if (w_tmo_hit) begin
                    w_data_nxt  = 32'hDEAD_DEAD;
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                // Insert only into an empty slot; occupied slots pass untouched.
                if (!r_rin[68]) begin
                    w_rout_nxt  = {1'b1, 1'b0, r_wr, r_id, r_mask, r_addr, r_seq, r_data};
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign rcn_out          = r_rout;
    assign av.av_address    = r_addr;
    assign av.av_read       = r_rd;
    assign av.av_write      = r_wt;
    assign av.av_byteenable = r_mask;
    assign av.av_writedata  = r_data;

endmodule

// File: tb/tb_rcn2avalon.sv
// Directed bench for rcn2avalon: transaction-level ring/Avalon model checked every cycle,
// plus literal expectations per scenario.
module tb_rcn2avalon;

    localparam logic [21:0] MASK = 22'h3F0000;
    localparam logic [21:0] BASE = 22'h000000;
`ifdef RCN2AVALON_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'd8;
`else
    localparam logic [15:0] TMO = 16'd255;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [68:0] rcn_in = '0;
    logic [68:0] rcn_out;

    rcn2avalon_if av_bus ();

    rcn2avalon #(
        .ADDR_MASK      (MASK),
        .ADDR_BASE      (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .av_clk   (clk),
        .av_rst_n (rst_n),
        .rcn_in   (rcn_in),
        .rcn_out  (rcn_out),
        .av       (av_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] req(input logic wr, input logic [5:0] id,
                                        input logic [3:0] mask, input logic [21:0] addr,
                                        input logic [1:0] seq, input logic [31:0] data);
        return {1'b1, 1'b1, wr, id, mask, addr, seq, data};
    endfunction

    // Avalon slave behaviour knobs
    int          cfg_wait = 0;
    int          cfg_lat = 2;
    logic [31:0] cfg_rdata = '0;

    initial begin
        int wcnt;
        int rd_cd;
        wcnt = 0;
        rd_cd = 0;
        av_bus.av_waitrequest   = 1'b0;
        av_bus.av_readdatavalid = 1'b0;
        av_bus.av_readdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            av_bus.av_readdatavalid = 1'b0;
            if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0) begin
                    av_bus.av_readdatavalid = 1'b1;
                    av_bus.av_readdata      = cfg_rdata;
                end
            end
            if (av_bus.av_read || av_bus.av_write) begin
                if (wcnt < cfg_wait) begin
                    av_bus.av_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    av_bus.av_waitrequest = 1'b0;
                    wcnt = 0;
                    if (av_bus.av_read) rd_cd = cfg_lat;
                end
            end else begin
                av_bus.av_waitrequest = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Model state and observation logs
    logic [68:0] m_rin = '0;
    logic [68:0] m_exp = '0;
    logic [68:0] m_cap = '0;
    logic [31:0] m_data = '0;
    bit          m_busy = 0, m_act = 0, m_rdw = 0, m_rdy = 0;
    int          m_tmo = 0;
    int          cyc = 0;
    int          n_wr_cyc = 0, n_rd_cyc = 0, n_rd_acc = 0;
    logic [21:0] last_addr = '0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wd = '0;
    logic [68:0] out_log[$];
    int          out_cyc[$];

    initial begin
        forever begin
            bit          acc, rdv, tmo, consume;
            logic [68:0] seen;
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_ring", rcn_out, '0);
                chk("rst_strobes", {av_bus.av_read, av_bus.av_write}, '0);
                chk("rst_av_fields", {av_bus.av_address, av_bus.av_byteenable,
                                      av_bus.av_writedata}, '0);
                m_rin = '0; m_exp = '0; m_busy = 0; m_act = 0; m_rdw = 0; m_rdy = 0;
                m_tmo = 0;
            end else begin
                chk("ring_out", rcn_out, m_exp);
                if (rcn_out[68]) begin
                    out_log.push_back(rcn_out);
                    out_cyc.push_back(cyc);
                end
                if (m_act) begin
                    chk("av_strobe", {av_bus.av_read, av_bus.av_write},
                        {~m_cap[66], m_cap[66]});
                    chk("av_fields", {av_bus.av_address, av_bus.av_byteenable,
                                      av_bus.av_writedata},
                        {m_cap[55:34], m_cap[59:56], m_cap[31:0]});
                end else begin
                    chk("av_idle", {av_bus.av_read, av_bus.av_write}, 2'b00);
                end
                if (av_bus.av_write) begin
                    n_wr_cyc++;
                    last_addr = av_bus.av_address;
                    last_be   = av_bus.av_byteenable;
                    last_wd   = av_bus.av_writedata;
                end
                if (av_bus.av_read) n_rd_cyc++;
                if (av_bus.av_read && !av_bus.av_waitrequest) n_rd_acc++;

                acc = m_act && !av_bus.av_waitrequest;
                rdv = m_rdw && av_bus.av_readdatavalid;
                tmo = 0;
`ifdef RCN2AVALON_TIMEOUT_EN
                tmo = ((m_act && !acc) || (m_rdw && !rdv)) && (m_tmo == int'(TMO) - 1);
                m_tmo++;
`endif
                // Ring decision taken at the coming edge, from the slot now held inside
                consume = 0;
                seen = m_rin;
                if (seen[68] && seen[67] && ((seen[55:34] & MASK) == (BASE & MASK))
                    && !m_busy) begin
                    m_exp = '0;
                    consume = 1;
                end else if (m_rdy && !seen[68]) begin
                    m_exp = {2'b10, m_cap[66:32], m_data};
                    m_rdy = 0;
                    m_busy = 0;
                end else begin
                    m_exp = seen;
                end
                m_rin = rcn_in;

                if (acc) begin
                    m_act = 0;
                    if (m_cap[66]) m_rdy = 1;
                    else m_rdw = 1;
                end
                if (rdv) begin
                    m_rdw = 0;
                    m_data = av_bus.av_readdata;
                    m_rdy = 1;
                end
                if (tmo) begin
                    m_act = 0;
                    m_rdw = 0;
                    m_data = 32'hDEAD_DEAD;
                    m_rdy = 1;
                end
                if (consume) begin
                    m_busy = 1;
                    m_act = 1;
                    m_cap = seen;
                    m_data = seen[31:0];
                    m_tmo = 0;
                end
            end
        end
    end

    task automatic drive(input logic [68:0] v);
        rcn_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0);
    endtask

    function automatic logic [68:0] filler(input int i);
        return {1'b1, 1'b0, 1'b0, 6'(i), 4'h0, 22'h3FFF00, 2'd0, 32'(i)};
    endfunction

    initial begin
        int          s0, a0;
        logic [68:0] va, vb;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // 1: in-window write, no wait states
        cfg_wait = 0;
        out_log.delete(); out_cyc.delete();
        s0 = n_wr_cyc;
        drive(req(1'b1, 6'h3F, 4'hF, 22'h000010, 2'd1, 32'h12345678));
        idle(8);
        chk("t1_wr_cycles", 69'(n_wr_cyc - s0), 69'd1);
        chk("t1_wr_fields", {last_addr, last_be, last_wd}, {22'h10, 4'hF, 32'h12345678});
        chk("t1_resp_count", 69'(out_log.size()), 69'd1);
        chk("t1_resp", out_log[0],
            {1'b1, 1'b0, 1'b1, 6'h3F, 4'hF, 22'h10, 2'd1, 32'h12345678});

        // 2: read with 3 wait states, data 2 cycles after accept
        cfg_wait = 3; cfg_lat = 2; cfg_rdata = 32'hCAFEF00D;
        out_log.delete(); out_cyc.delete();
        s0 = n_rd_cyc;
        drive(req(1'b0, 6'h15, 4'h3, 22'h000020, 2'd2, 32'h0));
        idle(12);
        chk("t2_rd_cycles", 69'(n_rd_cyc - s0), 69'd4);
        chk("t2_resp_count", 69'(out_log.size()), 69'd1);
        chk("t2_resp", out_log[0],
            {1'b1, 1'b0, 1'b0, 6'h15, 4'h3, 22'h20, 2'd2, 32'hCAFEF00D});

        // 3: out-of-window request and in-window response-type slot pass through
        cfg_wait = 0;
        out_log.delete(); out_cyc.delete();
        s0 = n_rd_cyc + n_wr_cyc;
        va = req(1'b1, 6'h01, 4'hF, 22'h010000, 2'd0, 32'hAAAA5555);
        vb = {1'b1, 1'b0, 1'b1, 6'h02, 4'hF, 22'h000010, 2'd3, 32'h0BADF00D};
        drive(va);
        drive(vb);
        idle(4);
        chk("t3_count", 69'(out_log.size()), 69'd2);
        chk("t3_miss", out_log[0], va);
        chk("t3_resp_type", out_log[1], vb);
        chk("t3_no_strobe", 69'(n_rd_cyc + n_wr_cyc - s0), 69'd0);

        // 4: second request while busy passes through, then is served on reinjection
        cfg_wait = 0; cfg_lat = 6; cfg_rdata = 32'h11112222;
        out_log.delete(); out_cyc.delete();
        a0 = n_rd_acc;
        va = req(1'b0, 6'h07, 4'hF, 22'h000030, 2'd0, 32'h0);
        vb = req(1'b0, 6'h08, 4'hF, 22'h000040, 2'd1, 32'h0);
        drive(va);
        idle(3);
        drive(vb);
        idle(12);
        chk("t4_passthru", out_log[0], vb);
        chk("t4_resp_a", out_log[1],
            {1'b1, 1'b0, 1'b0, 6'h07, 4'hF, 22'h30, 2'd0, 32'h11112222});
        drive(vb);
        idle(12);
        chk("t4_reads", 69'(n_rd_acc - a0), 69'd2);
        chk("t4_resp_b", out_log[out_log.size() - 1],
            {1'b1, 1'b0, 1'b0, 6'h08, 4'hF, 22'h40, 2'd1, 32'h11112222});

        // 5: response waits out 5 full slots, lands in the first empty one
        cfg_wait = 0;
        out_log.delete(); out_cyc.delete();
        drive(req(1'b1, 6'h2A, 4'h1, 22'h000050, 2'd3, 32'h55AA55AA));
        drive('0);
        for (int i = 0; i < 5; i++) drive(filler(i));
        idle(6);
        chk("t5_count", 69'(out_log.size()), 69'd6);
        chk("t5_last_filler", out_log[4], filler(4));
        chk("t5_resp", out_log[5],
            {1'b1, 1'b0, 1'b1, 6'h2A, 4'h1, 22'h50, 2'd3, 32'h55AA55AA});
        chk("t5_adjacent", 69'(out_cyc[5] - out_cyc[0]), 69'd5);

`ifdef RCN2AVALON_TIMEOUT_EN
        // 6: waitrequest stuck high, timeout after 8 strobe cycles
        cfg_wait = 1000;
        out_log.delete(); out_cyc.delete();
        s0 = n_wr_cyc;
        drive(req(1'b1, 6'h03, 4'hF, 22'h000010, 2'd0, 32'h00001234));
        idle(14);
        chk("t6_wr_cycles", 69'(n_wr_cyc - s0), 69'd8);
        chk("t6_resp", out_log[out_log.size() - 1],
            {1'b1, 1'b0, 1'b1, 6'h03, 4'hF, 22'h10, 2'd0, 32'hDEADDEAD});
        cfg_wait = 0;
        idle(2);
`endif

        // Reset asserted mid-AV_REQ drops the transaction
        cfg_wait = 1000;
        out_log.delete(); out_cyc.delete();
        drive(req(1'b1, 6'h04, 4'hF, 22'h000010, 2'd0, 32'h00000077));
        idle(3);
        chk("rst_pre_strobe", {av_bus.av_read, av_bus.av_write}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_strobes", {av_bus.av_read, av_bus.av_write}, 2'b00);
        chk("rst_async_fields", {av_bus.av_address, av_bus.av_byteenable,
                                 av_bus.av_writedata}, '0);
        chk("rst_async_ring", rcn_out, '0);
        cfg_wait = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);
        chk("rst_resp_lost", 69'(out_log.size()), 69'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
